inst_fetch_unit: RTL

Instruction fetch front end that sits directly upstream of the single-cycle core. It reads 32-bit instructions from a word-addressed instruction memory with variable latency. Each instruction is handed to the core as a one-cycle in_valid/inst pulse. The unit then waits for the core's out_valid/inst_addr completion, which supplies the next PC. A one-entry sequential prefetch buffer (PC+4) hides memory latency on straight-line code. A watchdog flags any core that exceeds the allowed execution latency.

---
 rtl/ifu_pkg.sv | 14 +
 rtl/inst_fetch_unit_if.sv | 25 ++
 rtl/ifu_prefetch_buf.sv | 53 +++++
 rtl/inst_fetch_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and helpers for the instruction fetch front end.
package ifu_pkg;
   localparam int unsigned INST_W = 32;
   localparam int unsigned ADDR_W = 32;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, ISSUE, WAIT_CORE, HALT} state_t;

   // Outcome of the fetch lookup, resolved on entry to FETCH and acted on when leaving it.
   typedef enum logic [1:0] {DEC_WAIT, DEC_HIT, DEC_MISS, DEC_BAD} dec_t;

   function automatic logic pc_ok(input logic [ADDR_W-1:0] pc, input int unsigned depth);
      return (pc[1:0] == 2'b00) && ((pc >> 2) < depth);
   endfunction
endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory and core handshake bundle seen by the fetch unit.
interface inst_fetch_unit_if
   import ifu_pkg::*;
#(
   parameter int unsigned IDX_W = 10
);
   logic              imem_req;
   logic [IDX_W-1:0]  imem_addr;
   logic              imem_rvalid;
   logic [INST_W-1:0] imem_rdata;
   logic              in_valid;
   logic [INST_W-1:0] inst;
   logic              out_valid;
   logic [ADDR_W-1:0] inst_addr;

   modport master (
      output imem_req, imem_addr, in_valid, inst,
      input  imem_rvalid, imem_rdata, out_valid, inst_addr
   );

   modport slave (
      input  imem_req, imem_addr, in_valid, inst,
      output imem_rvalid, imem_rdata, out_valid, inst_addr
   );
endinterface

// File: rtl/ifu_prefetch_buf.sv
// One-entry sequential prefetch buffer with outstanding-request tracking.
module ifu_prefetch_buf
   import ifu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              issue,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic              rvalid,
   input  logic [INST_W-1:0] rdata,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              pend_c,
   output logic              hit_c,
   output logic [INST_W-1:0] data_c
);
   logic              pend;
   logic [ADDR_W-1:0] pf_addr;
   logic              valid;
   logic [ADDR_W-1:0] addr;
   logic [INST_W-1:0] data;
   logic              fill;

   assign fill = pend && rvalid;

   // Lookup sees a response landing this cycle as if it were already stored.
   always_comb begin
      pend_c = pend && !rvalid;
      hit_c  = fill ? (pf_addr == lookup_addr) : (valid && (addr == lookup_addr));
      data_c = fill ? rdata : data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend    <= 1'b0;
         pf_addr <= '0;
         valid   <= 1'b0;
         addr    <= '0;
         data    <= '0;
      end else begin
         if (fill) begin
            valid <= 1'b1;
            addr  <= pf_addr;
            data  <= rdata;
         end
         if (issue) begin
            pend    <= 1'b1;
            pf_addr <= issue_addr;
         end else if (fill) begin
            pend <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch FSM: reads instructions, issues them to the core, prefetches PC+4 and
// watches core latency.
module inst_fetch_unit
   import ifu_pkg::*;
#(
   parameter int unsigned       DEPTH      = 1000,
   parameter int unsigned       IDX_W      = 10,
   parameter int unsigned       TIMEOUT    = 10,
   parameter logic [ADDR_W-1:0] START_ADDR = 32'd0
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   inst_fetch_unit_if.master         bus,
   output logic                      busy,
   output logic                      err_timeout,
   output logic                      err_range,
   output logic [31:0]               fetch_count
);
   localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;

   state_t            state;
   dec_t              dec;
   dec_t              dec_c;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] fpc;
   logic [ADDR_W-1:0] pf_addr;
   logic [TMR_W-1:0]  timer;
   logic              decide;
   logic              go_issue;
   logic              pf_issue;
   logic              pend_c;
   logic              hit_c;
   logic [INST_W-1:0] pbuf_data;

   ifu_prefetch_buf u_pbuf (
      .clk         (clk),
      .rst         (rst),
      .issue       (pf_issue),
      .issue_addr  (pf_addr),
      .rvalid      (bus.imem_rvalid),
      .rdata       (bus.imem_rdata),
      .lookup_addr (fpc),
      .pend_c      (pend_c),
      .hit_c       (hit_c),
      .data_c      (pbuf_data)
   );

   // The lookup runs on the PC being entered so a miss request is visible during FETCH.
   always_comb begin
      fpc = pc;
      if (state == IDLE)           fpc = START_ADDR;
      else if (state == WAIT_CORE) fpc = bus.inst_addr;

      if (pend_c)                    dec_c = DEC_WAIT;
      else if (!pc_ok(fpc, DEPTH))   dec_c = DEC_BAD;
      else if (hit_c)                dec_c = DEC_HIT;
      else                           dec_c = DEC_MISS;

      decide   = ((state == IDLE) && start) ||
                 ((state == WAIT_CORE) && bus.out_valid) ||
                 ((state == FETCH) && (dec == DEC_WAIT));
      go_issue = ((state == FETCH) && (dec == DEC_HIT)) ||
                 ((state == WAIT_MEM) && bus.imem_rvalid);
      pf_addr  = pc + 32'd4;
      pf_issue = go_issue && pc_ok(pf_addr, DEPTH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         dec             <= DEC_WAIT;
         pc              <= START_ADDR;
         timer           <= '0;
         bus.imem_req    <= 1'b0;
         bus.imem_addr   <= '0;
         bus.in_valid    <= 1'b0;
         bus.inst        <= '0;
         busy            <= 1'b0;
         err_timeout     <= 1'b0;
         err_range       <= 1'b0;
         fetch_count     <= '0;
      end else begin
         bus.imem_req <= 1'b0;
         bus.in_valid <= 1'b0;

         if (decide) begin
            dec <= dec_c;
            if (dec_c == DEC_MISS) begin
               bus.imem_req  <= 1'b1;
               bus.imem_addr <= fpc[IDX_W+1:2];
            end
         end

         if (pf_issue) begin
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= pf_addr[IDX_W+1:2];
         end

         if (go_issue) begin
            bus.in_valid <= 1'b1;
            fetch_count  <= fetch_count + 32'd1;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state <= FETCH;
                  pc    <= START_ADDR;
                  busy  <= 1'b1;
               end
            end
            FETCH: begin
               if (dec == DEC_HIT) begin
                  bus.inst <= pbuf_data;
                  state    <= ISSUE;
               end else if (dec == DEC_MISS) begin
                  state <= WAIT_MEM;
               end else if (dec == DEC_BAD) begin
                  err_range <= 1'b1;
                  busy      <= 1'b0;
                  state     <= HALT;
               end
            end
            WAIT_MEM: begin
               if (bus.imem_rvalid) begin
                  bus.inst <= bus.imem_rdata;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               timer <= '0;
               state <= WAIT_CORE;
            end
            WAIT_CORE: begin
               // A completion on the last allowed cycle still counts.
               if (bus.out_valid) begin
                  pc    <= bus.inst_addr;
                  state <= FETCH;
               end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                  err_timeout <= 1'b1;
                  busy        <= 1'b0;
                  state       <= HALT;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
